mips16_trace_tx: RTL
====================

# mips16_trace_tx

Hardware trace transmitter for the MIPS16 core: it samples the core's `pc_out`/`alu_result` pair on a strobe, buffers samples in a small FIFO, and serializes each as a framed 8N1 UART byte stream on one pin. It is the on-chip counterpart of the simulation bench: it makes the same observation points visible to a host on silicon. It sits beside `MIPS16` at top level, sharing its clock and reset.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per UART bit, at least 2.
- `FIFO_DEPTH`, 8, sample entries, a power of 2, at least 2.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `trace_valid`  in  1  capture strobe; sample taken on each rising edge where it is high.
- `pc_in`  in  16  connects to `MIPS16.pc_out`.
- `alu_in`  in  16  connects to `MIPS16.alu_result`.
- `tx`  out  1  UART serial output; idle high.
- `busy`  out  1  high while a frame is being sent or the FIFO is non-empty.
- `overflow`  out  1  sticky; set when a sample is dropped.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO entry count.

## Operation
- Capture:
  - `trace_valid`=1 pushes {pc_in, alu_in} (32 bits).
  - If the FIFO is full and no pop happens that cycle, the sample is dropped and `overflow` is set.
  - If the FIFO is full and a pop happens in the same cycle, the push is accepted and the level is unchanged.
- `overflow` clears only on reset.
- Frame: bytes in order `0xA5`, pc[15:8], pc[7:0], alu[15:8], alu[7:0].
- Byte format: each byte is 8N1: start bit 0, data bits LSB first, stop bit 1.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE→START when the FIFO is non-empty. The pop happens in this same cycle, the entry is latched into a frame register, and the byte index is set to 0.
  - START→DATA after CLKS_PER_BIT cycles.
  - DATA→STOP after 8 bits.
  - STOP→START with the next byte index when more bytes remain. Otherwise STOP→IDLE.
- The frame register is independent of the FIFO, so captures continue at full rate during transmission.
- Reset mid-frame: the frame is abandoned and `tx` returns high on the next cycle. FIFO contents are discarded.

## Timing
- Reset values: `tx`=1, `busy`=0, `overflow`=0, `fifo_level`=0, FSM=IDLE, baud counter=0, byte index=0.
- Capture: `fifo_level` reflects a push one cycle after the sampling edge.
- Pop latency: with an empty FIFO and idle FSM, a sample captured at edge N is popped at edge N+1. `tx` goes low after edge N+2.
- Bit time: each bit holds `tx` for exactly CLKS_PER_BIT cycles.
- Bytes within a frame are back-to-back with no idle gap.
- Frame length: 5 × 10 × CLKS_PER_BIT cycles.
- Between frames, `tx` is high for exactly 1 cycle (the IDLE state) before the next start bit.
- `busy` is combinational: (state≠IDLE) or (fifo_level≠0).
- `tx` is driven from a register, so there are no glitches.

## Configuration
- `MIPS16_TRACE_CHECKSUM_EN` defined:
  - Frame is 6 bytes; the last byte is the XOR of the four payload bytes.
  - Frame length is 60 × CLKS_PER_BIT cycles.
- Undefined: the frame is 5 bytes with no checksum.

## Structure
- Package `mips16_trace_pkg`:
  - `TRACE_SYNC` = 8'hA5.
  - FSM state enum.
  - `TRACE_FRAME_BYTES` (5, or 6 under the macro).
  - `trace_entry_t` struct {pc, alu}.
- Sub-module `mips16_trace_fifo`:
  - Synchronous FIFO, parameterized depth.
  - Push/pop/full/empty/level.
  - Handles simultaneous push and pop, including when full.
- The top holds the FSM, baud counter, bit counter, byte index, and frame register.

## Test plan
- Single sample, CLKS_PER_BIT=4: pc=0x0004, alu=0x0010, one-cycle strobe → bytes A5 00 04 00 10 decoded. `tx` low starts 2 cycles after the strobe edge. `busy` drops 200 cycles later.
- Checksum build, same stimulus → bytes A5 00 04 00 10 14, lasting 240 cycles.
- FIFO_DEPTH=4, `trace_valid` held for 10 cycles from an idle state → 1 sample popped plus 4 buffered. `overflow`=1. Exactly 5 frames emitted, with consecutive PCs matching the first 5 samples.
- Full FIFO with a strobe on the cycle of an IDLE→START pop → push accepted. `fifo_level` stays at FIFO_DEPTH and `overflow` remains 0.
- Reset asserted during the DATA bit of byte 2 → `tx`=1, `busy`=0, `fifo_level`=0 on the next cycle. After release, a new sample transmits a complete frame.
- Two frames back-to-back → exactly 1 idle-high cycle between the stop bit of frame 1 and the start bit of frame 2.

Source files
------------

// File: rtl/mips16_trace_pkg.sv
// mips16_trace_pkg: shared types and constants for the MIPS16 trace transmitter.
//   TRACE_SYNC        - first byte of each frame
//   TRACE_FRAME_BYTES - bytes per frame (6 with MIPS16_TRACE_CHECKSUM_EN, else 5)
//   trace_state_e     - serializer FSM states
//   trace_entry_t     - one captured sample {pc, alu}
//   trace_byte()      - selects frame byte idx from a sample
// Config macro: MIPS16_TRACE_CHECKSUM_EN appends an XOR checksum byte.
package mips16_trace_pkg;
  localparam logic [7:0] TRACE_SYNC = 8'hA5;
`ifdef MIPS16_TRACE_CHECKSUM_EN
  localparam int TRACE_FRAME_BYTES = 6;
`else
  localparam int TRACE_FRAME_BYTES = 5;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} trace_state_e;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] alu;
  } trace_entry_t;

  // Byte 5 only exists in the checksum build; it is the XOR of the payload.
  function automatic logic [7:0] trace_byte(input trace_entry_t e, input logic [2:0] idx);
    case (idx)
      3'd0:    trace_byte = TRACE_SYNC;
      3'd1:    trace_byte = e.pc[15:8];
      3'd2:    trace_byte = e.pc[7:0];
      3'd3:    trace_byte = e.alu[15:8];
      3'd4:    trace_byte = e.alu[7:0];
      default: trace_byte = e.pc[15:8] ^ e.pc[7:0] ^ e.alu[15:8] ^ e.alu[7:0];
    endcase
  endfunction
endpackage

// File: rtl/mips16_trace_fifo.sv
// mips16_trace_fifo: synchronous FIFO of trace samples.
//   clk, reset (sync, active low)
//   push/din  - write request and data
//   pop/dout  - read request; dout shows the head entry (first-word fall-through)
//   full, empty, level - occupancy
//   drop      - push refused this cycle (full with no pop)
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module mips16_trace_fifo
  import mips16_trace_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  trace_entry_t  din,
  input  logic          pop,
  output trace_entry_t  dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level,
  output logic          drop
);
  trace_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of 2, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/mips16_trace_tx.sv
// mips16_trace_tx: captures {pc_in, alu_in} on trace_valid, buffers the
// samples and sends each as a framed 8N1 UART byte stream on tx.
//   clk, reset (sync, active low)
//   trace_valid, pc_in, alu_in - sample strobe and data
//   tx         - serial out, idle high, registered
//   busy       - frame in flight or samples pending
//   overflow   - sticky, a sample was dropped
//   fifo_level - buffered sample count
// Config macro: MIPS16_TRACE_CHECKSUM_EN adds a trailing XOR checksum byte.
module mips16_trace_tx
  import mips16_trace_pkg::*;
#(
  parameter  int CLKS_PER_BIT = 434,
  parameter  int FIFO_DEPTH   = 8,
  localparam int LW           = $clog2(FIFO_DEPTH) + 1,
  localparam int CW           = $clog2(CLKS_PER_BIT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          trace_valid,
  input  logic [15:0]   pc_in,
  input  logic [15:0]   alu_in,
  output logic          tx,
  output logic          busy,
  output logic          overflow,
  output logic [LW-1:0] fifo_level
);
  trace_state_e  state, state_d;
  logic [CW-1:0] baud, baud_d;
  logic [2:0]    bit_cnt, bit_d;
  logic [2:0]    byte_idx, idx_d;
  trace_entry_t  frame, fifo_dout;
  logic          fifo_full, fifo_empty, fifo_drop;
  logic          pop, tx_d, bit_end;
  logic [7:0]    cur_byte;

  mips16_trace_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (trace_valid),
    .din   ({pc_in, alu_in}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level),
    .drop  (fifo_drop)
  );

  assign busy     = (state != IDLE) || (fifo_level != '0);
  assign bit_end  = (baud == CW'(CLKS_PER_BIT - 1));
  assign cur_byte = trace_byte(frame, byte_idx);

  // tx_d is the level for the current state; tx registers it, so the line
  // lags the state by one cycle but every bit still lasts CLKS_PER_BIT.
  always_comb begin
    state_d = state;
    baud_d  = baud;
    bit_d   = bit_cnt;
    idx_d   = byte_idx;
    pop     = 1'b0;
    tx_d    = 1'b1;
    if (state != IDLE) baud_d = bit_end ? '0 : baud + 1'b1;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = START;
          idx_d   = '0;
          baud_d  = '0;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        tx_d = cur_byte[bit_cnt];
        if (bit_end) begin
          if (bit_cnt == 3'd7) state_d = STOP;
          else                 bit_d   = bit_cnt + 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (byte_idx == 3'(TRACE_FRAME_BYTES - 1)) begin
            state_d = IDLE;
          end else begin
            idx_d   = byte_idx + 1'b1;
            state_d = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      baud     <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      frame    <= '0;
      tx       <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state    <= state_d;
      baud     <= baud_d;
      bit_cnt  <= bit_d;
      byte_idx <= idx_d;
      tx       <= tx_d;
      if (pop)       frame    <= fifo_dout;
      if (fifo_drop) overflow <= 1'b1;
    end
  end
endmodule
